// File: rtl/ppu_pkg.sv
// Shared posit-unit sizing and operation encoding.
// Widths are derived from the posit width N through the helper functions.
package ppu_pkg;

  localparam int POSIT_N = 16;
  localparam int POSIT_ES = 1;

  function automatic int te_size(input int n);
    return POSIT_ES + $clog2(n) + 2;
  endfunction

  function automatic int mant_size(input int n);
    return n - 2;
  endfunction

  localparam int TE_SIZE = te_size(POSIT_N);
  localparam int MANT_SIZE = mant_size(POSIT_N);
  localparam int MANT_ADD_RESULT_SIZE = MANT_SIZE + 1;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

endpackage

// File: rtl/shift_right_sticky.sv
// Logical right shift that ORs every bit shifted past the LSB into a sticky flag.
// Shift amounts of W or more clear the result and fold the whole input into sticky.
module shift_right_sticky #(
  parameter int W = 15,
  parameter int SW = 4
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  shifted,
  output logic          sticky
);

  always_comb begin
    shifted = '0;
    sticky = 1'b0;
    if (32'(shamt) >= W) begin
      shifted = '0;
      sticky = |data;
    end else begin
      shifted = data >> shamt;
      sticky = |(data & ~({W{1'b1}} << shamt));
    end
  end

endmodule

// File: rtl/add_align_pipe.sv
// Two-stage posit adder front end: orders operands, aligns the smaller mantissa
// to the larger exponent and produces the unnormalised sum or difference.
module add_align_pipe
  import ppu_pkg::*;
#(
  parameter int N = 16,
  localparam int TE_W = te_size(N),
  localparam int MANT_W = mant_size(N),
  localparam int MADD_W = MANT_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a_sign,
  input  logic [TE_W-1:0]   a_te,
  input  logic [MANT_W-1:0] a_mant,
  input  logic              b_sign,
  input  logic [TE_W-1:0]   b_te,
  input  logic [MANT_W-1:0] b_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MADD_W-1:0] out_mant,
  output logic [TE_W-1:0]   out_te,
  output logic              out_sign,
  output logic              out_sticky,
  output logic              out_zero
);

  localparam int SH_W = $clog2(MADD_W + 1);

  logic advance;

  logic              a_big;
  logic [TE_W:0]     te_diff;
  logic [SH_W-1:0]   shamt_sat;

  logic              s1_valid;
  logic [MANT_W-1:0] s1_big_mant;
  logic [MANT_W-1:0] s1_small_mant;
  logic [SH_W-1:0]   s1_shamt;
  op_t               s1_op;
  logic              s1_sign;
  logic [TE_W-1:0]   s1_te;

  logic [MADD_W-1:0] small_aligned;
  logic              small_sticky;
  logic [MADD_W-1:0] sum;
  logic              sum_zero;

  // One global enable: every stage moves together or the whole pipe stalls.
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    a_big = ($signed(a_te) > $signed(b_te)) ||
            ((a_te == b_te) && (a_mant >= b_mant));
    // Sign-extended by one bit; the big-minus-small difference is never negative.
    if (a_big)
      te_diff = {a_te[TE_W-1], a_te} - {b_te[TE_W-1], b_te};
    else
      te_diff = {b_te[TE_W-1], b_te} - {a_te[TE_W-1], a_te};
    if (te_diff >= (TE_W + 1)'(MADD_W))
      shamt_sat = SH_W'(MADD_W);
    else
      shamt_sat = te_diff[SH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_big_mant   <= '0;
      s1_small_mant <= '0;
      s1_shamt      <= '0;
      s1_op         <= ADD;
      s1_sign       <= 1'b0;
      s1_te         <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_big_mant   <= a_big ? a_mant : b_mant;
        s1_small_mant <= a_big ? b_mant : a_mant;
        s1_shamt      <= shamt_sat;
        s1_op         <= (a_sign == b_sign) ? ADD : SUB;
        s1_sign       <= a_big ? a_sign : b_sign;
        s1_te         <= a_big ? a_te : b_te;
      end
    end
  end

  shift_right_sticky #(
    .W (MADD_W),
    .SW(SH_W)
  ) u_shift (
    .data   ({1'b0, s1_small_mant}),
    .shamt  (s1_shamt),
    .shifted(small_aligned),
    .sticky (small_sticky)
  );

  always_comb begin
    if (s1_op == ADD)
      sum = {1'b0, s1_big_mant} + small_aligned;
    else
      sum = {1'b0, s1_big_mant} - small_aligned;
    sum_zero = (sum == '0) && !small_sticky;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_mant   <= '0;
      out_te     <= '0;
      out_sign   <= 1'b0;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant   <= sum;
        out_te     <= s1_te;
        out_sign   <= sum_zero ? 1'b0 : s1_sign;
        out_sticky <= small_sticky;
        out_zero   <= sum_zero;
      end
    end
  end

endmodule

// File: tb/tb_add_align_pipe.sv
// Self-checking bench for add_align_pipe: directed spec vectors, stalls,
// reset mid-flight and randomized traffic against an arithmetic reference model.
module tb_add_align_pipe;
  import ppu_pkg::*;

  localparam int RW = MANT_ADD_RESULT_SIZE;

  typedef struct packed {
    logic                 a_sign;
    logic [TE_SIZE-1:0]   a_te;
    logic [MANT_SIZE-1:0] a_mant;
    logic                 b_sign;
    logic [TE_SIZE-1:0]   b_te;
    logic [MANT_SIZE-1:0] b_mant;
  } pair_t;

  typedef struct packed {
    logic [RW-1:0]      mant;
    logic [TE_SIZE-1:0] te;
    logic               sign;
    logic               sticky;
    logic               zero;
  } res_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 a_sign, b_sign;
  logic [TE_SIZE-1:0]   a_te, b_te;
  logic [MANT_SIZE-1:0] a_mant, b_mant;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        out_mant;
  logic [TE_SIZE-1:0]   out_te;
  logic                 out_sign, out_sticky, out_zero;

  int checks = 0;
  int errors = 0;

  res_t obs_q[$];
  res_t exp_q[$];
  res_t mon_r;

  add_align_pipe #(.N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sign    (a_sign),
    .a_te      (a_te),
    .a_mant    (a_mant),
    .b_sign    (b_sign),
    .b_te      (b_te),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_te    (out_te),
    .out_sign  (out_sign),
    .out_sticky(out_sticky),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_out();
    res_t r;
    r.mant = out_mant;
    r.te = out_te;
    r.sign = out_sign;
    r.sticky = out_sticky;
    r.zero = out_zero;
    return r;
  endfunction

  // Records every result transferred (valid && ready at the coming edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_r = cur_out();
      obs_q.push_back(mon_r);
    end
  end

  // Reference: real-valued alignment rules with plain integer arithmetic.
  function automatic res_t model(input pair_t p);
    res_t r;
    int ate, bte, big_m, small_m, big_t, small_t, d, aligned, sum;
    bit big_s, a_is_big, stk;
    ate = int'($signed(p.a_te));
    bte = int'($signed(p.b_te));
    a_is_big = (ate > bte) || (ate == bte && p.a_mant >= p.b_mant);
    big_m   = a_is_big ? int'(p.a_mant) : int'(p.b_mant);
    small_m = a_is_big ? int'(p.b_mant) : int'(p.a_mant);
    big_t   = a_is_big ? ate : bte;
    small_t = a_is_big ? bte : ate;
    big_s   = a_is_big ? p.a_sign : p.b_sign;
    d = big_t - small_t;
    if (d >= RW) begin
      aligned = 0;
      stk = (small_m != 0);
    end else begin
      aligned = small_m / (1 << d);
      stk = (small_m % (1 << d)) != 0;
    end
    sum = (p.a_sign == p.b_sign) ? big_m + aligned : big_m - aligned;
    r.mant = sum[RW-1:0];
    r.te = big_t[TE_SIZE-1:0];
    r.sticky = stk;
    r.zero = (sum == 0) && !stk;
    r.sign = r.zero ? 1'b0 : big_s;
    return r;
  endfunction

  function automatic pair_t rand_pair();
    pair_t p;
    int t;
    p.a_sign = 1'($urandom);
    p.b_sign = 1'($urandom);
    t = int'($urandom_range(0, 40)) - 20;
    p.a_te = t[TE_SIZE-1:0];
    t = int'($urandom_range(0, 40)) - 20;
    p.b_te = t[TE_SIZE-1:0];
    p.a_mant = MANT_SIZE'($urandom);
    p.a_mant[MANT_SIZE-1] = 1'b1;
    p.b_mant = MANT_SIZE'($urandom);
    p.b_mant[MANT_SIZE-1] = 1'b1;
    if ($urandom_range(0, 3) == 0) p.b_te = p.a_te;
    if ($urandom_range(0, 7) == 0) p.b_mant = p.a_mant;
    return p;
  endfunction

  task automatic drive(input pair_t p);
    a_sign = p.a_sign; a_te = p.a_te; a_mant = p.a_mant;
    b_sign = p.b_sign; b_te = p.b_te; b_mant = p.b_mant;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive('0);
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_out() !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b out=%h, want valid=0 ready=1 out=0",
               out_valid, in_ready, cur_out());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    pair_t v[6];
    res_t  e[6];
    string nm[6];
    v[0] = '{1'b0, 7'd0,  14'h2000, 1'b0, 7'd0, 14'h2000}; e[0] = '{15'h4000, 7'd0,  1'b0, 1'b0, 1'b0}; nm[0] = "one_plus_one";
    v[1] = '{1'b0, 7'd3,  14'h2000, 1'b0, 7'd0, 14'h2000}; e[1] = '{15'h2400, 7'd3,  1'b0, 1'b0, 1'b0}; nm[1] = "shift3";
    v[2] = '{1'b0, 7'd0,  14'h2000, 1'b0, 7'd3, 14'h2000}; e[2] = '{15'h2400, 7'd3,  1'b0, 1'b0, 1'b0}; nm[2] = "shift3_swapped";
    v[3] = '{1'b0, 7'd0,  14'h2000, 1'b1, 7'd0, 14'h2000}; e[3] = '{15'h0000, 7'd0,  1'b0, 1'b0, 1'b1}; nm[3] = "exact_zero";
    v[4] = '{1'b1, 7'd0,  14'h3000, 1'b0, 7'd0, 14'h2000}; e[4] = '{15'h1000, 7'd0,  1'b1, 1'b0, 1'b0}; nm[4] = "neg_diff";
    v[5] = '{1'b0, 7'd20, 14'h2000, 1'b0, 7'd0, 14'h2001}; e[5] = '{15'h2000, 7'd20, 1'b0, 1'b1, 1'b0}; nm[5] = "saturated_sticky";
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_latency1: out_valid=%b after 1 cycle, want 0", nm[i], out_valid);
      end
      @(posedge clk); #3;
      checks++;
      if (out_valid !== 1'b1 || cur_out() !== e[i]) begin
        errors++;
        $display("FAIL %s: valid=%b out=%h, want valid=1 out=%h", nm[i], out_valid, cur_out(), e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    pair_t p[8];
    res_t held;
    int idx = 0;
    int cyc = 0;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) p[i] = rand_pair();
    while ((idx < 8 || obs_q.size() < 8) && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = (idx < 8);
      if (idx < 8) drive(p[idx]);
      #2;
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d: in_ready=%b, want 0", cyc, in_ready);
        end
      end
      if (cyc == 3) held = cur_out();
      if (cyc == 4 || cyc == 5) begin
        checks++;
        if (out_valid !== 1'b1 || cur_out() !== held) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d: valid=%b out=%h, want valid=1 out=%h", cyc, out_valid, cur_out(), held);
        end
      end
      @(posedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(p[idx]));
        idx++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d results for %0d accepted, want 8/8", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_result%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    pair_t p0, p1, p2;
    res_t e;
    int wait_cyc;
    p0 = rand_pair(); p1 = rand_pair(); p2 = rand_pair();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(p0);
    @(posedge clk); #1;
    drive(p1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_inflight: out_valid=%b before reset, want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_out() !== '0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b ready=%b out=%h, want 0/1/0", out_valid, in_ready, cur_out());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    out_ready = 1'b1;
    e = model(p2);
    drive(p2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc = 0;
    while (obs_q.size() == 0 && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d results after release, want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== e) begin
        errors++;
        $display("FAIL midreset_result: got %h, want %h", obs_q[0], e);
      end
    end
  endtask

  task automatic test_random();
    pair_t p;
    res_t held;
    logic was_stalled = 1'b0;
    int sent = 0;
    int cyc = 0;
    obs_q.delete();
    exp_q.delete();
    p = rand_pair();
    while ((sent < 150 || obs_q.size() < 150) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid = (sent < 150) && ($urandom_range(0, 3) != 0);
      drive(p);
      #2;
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cur_out() !== held) begin
          errors++;
          $display("FAIL rand_hold cyc%0d: valid=%b out=%h, want valid=1 out=%h", cyc, out_valid, cur_out(), held);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready cyc%0d: in_ready=%b, want %b", cyc, in_ready, !out_valid || out_ready);
      end
      was_stalled = out_valid && !out_ready;
      held = cur_out();
      @(posedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(p));
        sent++;
        p = rand_pair();
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 150) begin
      errors++;
      $display("FAIL rand_count: got %0d results for %0d accepted, want 150/150", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_result%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_align_pipe.md
ADD_ALIGN_PIPE -- requirements
Module: add_align_pipe

Interface
REQ-001 SHALL have parameter N, default 16, posit width; derived widths TE_SIZE, MANT_SIZE, MANT_ADD_RESULT_SIZE (= MANT_SIZE+1) SHALL come from ppu_pkg.
REQ-002 SHALL have clk  input  1  single clock; all state rising-edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have in_valid  input  1  operand pair present.
REQ-005 SHALL have in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-006 SHALL have a_sign, b_sign  input  1 each  operand signs.
REQ-007 SHALL have a_te, b_te  input  TE_SIZE each  signed total exponents.
REQ-008 SHALL have a_mant, b_mant  input  MANT_SIZE each  mantissas, hidden bit at MSB (value 1.f).
REQ-009 SHALL have out_valid  output  1, out_ready  input  1  result handshake.
REQ-010 SHALL have out_mant  output  MANT_ADD_RESULT_SIZE  aligned sum/difference magnitude, MSB = carry position.
REQ-011 SHALL have out_te  output  TE_SIZE  exponent of larger operand.
REQ-012 SHALL have out_sign  output  1; out_sticky  output  1  OR of shifted-out bits; out_zero  output  1  exact-zero result.

Function
REQ-013 Latency SHALL be exactly 2 cycles from accepted input to out_valid when out_ready stays high; throughput one pair per cycle.
REQ-014 Stage 1 SHALL register: big/small selection, shift amount, op (add if a_sign==b_sign else subtract), big sign, big te.
REQ-015 Big operand SHALL be a if signed a_te > b_te, or a_te == b_te and a_mant >= b_mant; else b.
REQ-016 Shift amount SHALL be big_te - small_te (non-negative, TE_SIZE bits), saturated to MANT_ADD_RESULT_SIZE.
REQ-017 Stage 2 SHALL zero-extend both mantissas by one MSB, shift small right by shift amount, then add or subtract (big - small), registering result.
REQ-018 out_sticky SHALL be OR of all small-mantissa bits shifted out; 0 when shift is 0.
REQ-019 When shift >= MANT_ADD_RESULT_SIZE, aligned small SHALL be 0 and out_sticky = |small_mant.
REQ-020 out_sign SHALL be big sign; out_zero SHALL be 1 iff out_mant == 0 and out_sticky == 0, in which case out_sign SHALL be 0.
REQ-021 Pipeline SHALL advance globally when advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no in_valid dependency).
REQ-022 When advance=0, all stage registers and outputs SHALL hold; out_* SHALL stay stable while out_valid && !out_ready.
REQ-023 Stage valid bits SHALL propagate bubbles: an empty stage 1 moving forward SHALL clear out_valid.
REQ-024 Simultaneous output consume and input accept in one cycle SHALL lose no data and duplicate none.

Reset
REQ-025 On rst all valid bits SHALL clear immediately (out_valid=0), all data registers and out_mant, out_te, out_sign, out_sticky, out_zero SHALL be 0; in_ready SHALL read 1 during and after reset.
REQ-026 Reset mid-operation SHALL discard in-flight pairs; first result after release comes only from pairs accepted after release.

Structure
REQ-027 TE_SIZE, MANT_SIZE, MANT_ADD_RESULT_SIZE and the op enum (ADD, SUB) SHALL live in ppu_pkg.
REQ-028 Right-shift-with-sticky SHALL be one sub-module, shift_right_sticky; compare/swap and add/sub SHALL be inline.
REQ-029 Output feeds core_add directly (out_mant -> mant, out_te -> te_diff); no normalization in this block.

Verification (N=16, MANT_SIZE=14; 1.0 = 14'h2000)
REQ-030 a=+1.0 te 0, b=+1.0 te 0 -> after 2 cycles out_mant=15'h4000, out_te=0, sign 0, sticky 0, zero 0.
REQ-031 a=+1.0 te 3, b=+1.0 te 0 -> out_mant=15'h2400, out_te=3, sticky 0; swapped operands give identical result.
REQ-032 a=+1.0 te 0, b=-1.0 te 0 -> out_mant=0, out_zero=1, out_sign=0; a=-(14'h3000) te 0, b=+1.0 te 0 -> out_mant=15'h1000, sign 1.
REQ-033 a=+1.0 te 20, b=+14'h2001 te 0 -> out_mant=15'h2000, out_te=20, sticky 1.
REQ-034 Back-to-back 8 pairs with out_ready low cycles 3-5 -> in_ready low those cycles, outputs held, all 8 results in order, none lost/duplicated.
REQ-035 rst asserted while 2 pairs in flight -> out_valid=0 same cycle, no stale result after release.
